// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared defaults and FSM state encodings for imem_loader (IMEM_LOADER_CSUM_EN adds CHECK)
package imem_loader_pkg;

  // Default word-address width: 2^10 words of 32 bits.
  localparam int IMEM_AW_DEFAULT = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
`ifdef IMEM_LOADER_CSUM_EN
    ST_CHECK = 3'd3,
`endif
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write bus of imem_loader
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int AW = IMEM_AW_DEFAULT
) ();

  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          we;
  logic [AW+1:0] waddr;
  logic [31:0]   wdata;

  // Loader side: consumes bytes, drives memory writes.
  modport master (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output we,
    output waddr,
    output wdata
  );

  // Source/memory side.
  modport slave (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  we,
    input  waddr,
    input  wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - assembles four bytes little-endian into one 32-bit word
module imem_loader_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        full
);

  logic [1:0] lane;

  // Store each accepted byte in its lane; lane index wraps after byte 3.
  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      lane <= 2'd0;
    end else if (clr) begin
      word <= '0;
      lane <= 2'd0;
    end else if (load) begin
      word[{lane, 3'b000} +: 8] <= byte_in;
      lane                      <= lane + 2'd1;
    end
  end

  // Lane 3 is pending: the next accepted byte completes the word.
  assign full = (lane == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a byte stream into instruction memory while holding the CPU; IMEM_LOADER_CSUM_EN enables XOR checksum
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int AW = IMEM_AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] len_words,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] len_q;
  logic [AW-1:0] word_cnt;
  logic          start_ok;
  logic          accept;
  logic          pack_load;
  logic          lane_full;
  logic          last_word;
  logic          ready_c;
  logic          we_c;
  logic          hold_c;
  logic          done_c;
  logic [31:0]   word;

  assign start_ok  = (state == ST_IDLE) && start;
  assign accept    = bus.byte_valid && ready_c;
  assign pack_load = accept && (state == ST_RECV);
  assign last_word = (word_cnt == len_q - AW'(1));

  imem_loader_byte_packer u_byte_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_ok),
    .load    (pack_load),
    .byte_in (bus.byte_in),
    .word    (word),
    .full    (lane_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Length latch and word counter; the counter wraps naturally at 2^AW.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      word_cnt <= '0;
    end else if (start_ok) begin
      len_q    <= len_words;
      word_cnt <= '0;
    end else if (state == ST_WRITE) begin
      word_cnt <= word_cnt + AW'(1);
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    we_c      = 1'b0;
    hold_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (len_words == '0) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        ready_c = 1'b1;
        hold_c  = 1'b1;
        if (accept && lane_full) begin
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        we_c   = 1'b1;
        hold_c = 1'b1;
        if (last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_nxt = ST_CHECK;
`else
          state_nxt = ST_DONE;
`endif
        end else begin
          state_nxt = ST_RECV;
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      ST_CHECK: begin
        ready_c = 1'b1;
        hold_c  = 1'b1;
        if (accept) begin
          state_nxt = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        done_c    = 1'b1;
        hold_c    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.byte_ready = ready_c;
  assign bus.we         = we_c;
  assign bus.waddr      = {word_cnt, 2'b00};
  assign bus.wdata      = word;
  assign cpu_hold       = hold_c;
  assign done           = done_c;

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] csum;
  logic       err_q;

  // Running XOR of payload bytes; the trailing byte is compared in CHECK and a mismatch sticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else if (start_ok) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else begin
      if (pack_load) begin
        csum <= csum ^ bus.byte_in;
      end
      if ((state == ST_CHECK) && accept && (bus.byte_in != csum)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
- REQ-001: Parameter AW, default 10; word-address width; instruction memory holds 2^AW 32-bit words (4 KB at default).
- REQ-002: Port clk, input, 1; sole clock; all logic on rising edge.
- REQ-003: Port rst, input, 1; reset is synchronous and active-high.
- REQ-004: Port start, input, 1; one-cycle request to begin a program load; sampled only in IDLE.
- REQ-005: Port len_words, input, AW; number of words to load; latched on accepted start.
- REQ-006: Port byte_in, input, 8; incoming program byte stream.
- REQ-007: Port byte_valid, input, 1; byte_in holds a valid byte.
- REQ-008: Port byte_ready, output, 1; loader accepts a byte this cycle; transfer occurs when byte_valid && byte_ready.
- REQ-009: Port we, output, 1; instruction-memory word write strobe.
- REQ-010: Port waddr, output, AW+2; byte address of the write, always word-aligned (waddr[1:0]=0).
- REQ-011: Port wdata, output, 32; assembled instruction word.
- REQ-012: Port cpu_hold, output, 1; holds the CPU fetch stage while a load is in progress.
- REQ-013: Port done, output, 1; one-cycle pulse when a load completes.
- REQ-014: Port err, output, 1; checksum mismatch flag (see Configuration).

Function
- REQ-015: FSM states: IDLE, RECV, WRITE, CHECK, DONE.
- REQ-016: IDLE: byte_ready=0, we=0, cpu_hold=0; start=1 latches len_words, clears word counter and byte index, then goes to RECV, or to DONE if len_words=0.
- REQ-017: RECV: byte_ready=1, cpu_hold=1; each accepted byte is stored at lane byte_idx, little-endian (first byte -> wdata[7:0], fourth -> wdata[31:24]); byte_idx increments modulo 4.
- REQ-018: Acceptance of the fourth byte moves the FSM to WRITE on the next cycle.
- REQ-019: WRITE lasts exactly one cycle: we=1, waddr={word_cnt,2'b00}, wdata=assembled word, byte_ready=0.
- REQ-020: After WRITE, word_cnt increments; if the written word was number len_words-1, go to CHECK (macro on) or DONE (macro off); otherwise return to RECV.
- REQ-021: Word counter wraps at 2^AW with no error; a later word overwrites address 0.
- REQ-022: Bytes presented while byte_ready=0 are not consumed; the loader never drops an accepted byte.
- REQ-023: DONE lasts one cycle: done=1, cpu_hold=1; the FSM then returns to IDLE.
- REQ-024: start is ignored outside IDLE.
- REQ-025: Latency: minimum 5 cycles per word (4 accept cycles plus 1 WRITE cycle) at continuous byte_valid.

Reset
- REQ-026: While rst=1 on a clock edge: state=IDLE; byte_ready, we, cpu_hold, done, err=0; waddr, wdata, word_cnt, byte_idx=0.
- REQ-027: Reset mid-load aborts the load; no write of a partial word occurs; words already written remain in memory.

Configuration
- REQ-028: Macro IMEM_LOADER_CSUM_EN compiles in checksum checking.
- REQ-029: With the macro defined: a running XOR covers all data bytes; CHECK asserts byte_ready=1 and accepts one trailing byte; on mismatch err=1 (sticky until next accepted start or rst); then DONE.
- REQ-030: Without the macro: the CHECK state, XOR register, and trailing byte do not exist; err is tied to 0.

Structure
- REQ-031: FSM state encodings and the default AW live in the shared define header used by the core (alongside `N).
- REQ-032: Sub-module byte_packer (4-byte little-endian shift/assemble with lane index and full flag) is instantiated once; the FSM resides in imem_loader.

Verification
- REQ-033: len_words=2 with bytes 00,55,AA,FF,88,11,22,33 sent continuously -> we pulses with waddr=0x000, wdata=0xFFAA5500, then waddr=0x004, wdata=0x33221188; done pulses 1 cycle after the second WRITE (macro off).
- REQ-034: byte_valid toggled every other cycle, len_words=1 -> identical wdata; byte_ready=0 during WRITE and no byte is lost.
- REQ-035: len_words=0, start=1 -> done pulses 1 cycle later; we never asserts; cpu_hold high for exactly one cycle.
- REQ-036: rst asserted after 2 bytes of word 1 of a 3-word load -> all outputs 0 next cycle; no we; a fresh start reloads from waddr=0.
- REQ-037: Macro on, 1 word 01,02,03,04 with trailing byte 04 -> err=0; with trailing byte 05 -> err=1 held until next start.
- REQ-038: start pulsed during RECV -> ignored; len_words and word_cnt unchanged.
